// File: rtl/head_result_sequencer.sv
// Sequencing front end for the head-pruning mean/threshold unit: loads two 4x4 result
// matrices, runs the enable/compare protocol, reports the prune decision. Optional PRUNE_STATS_EN.
module head_result_sequencer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned SAMPLE_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [8*WIDTH-1:0]    row_data,
  output logic [32*WIDTH-1:0]   m1_flat,
  output logic [32*WIDTH-1:0]   m2_flat,
  output logic                  mean_enable,
  output logic                  mean_compare,
  input  logic                  prune_head,
  output logic                  mean_clear,
  output logic                  decision_valid,
  output logic                  decision_prune,
  input  logic                  decision_ready,
`ifdef PRUNE_STATS_EN
  output logic [7:0]            head_cnt,
  output logic [7:0]            pruned_cnt,
`endif
  output logic                  busy
);

  localparam int unsigned ROW_W   = 8 * WIDTH;
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > SAMPLE_DELAY) ? HOLD_CYCLES : SAMPLE_DELAY;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'((SAMPLE_DELAY == 0) ? 0 : SAMPLE_DELAY - 1);

  typedef enum logic [2:0] {
    LOAD1  = 3'd0,
    LOAD2  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [1:0]       cnt, cnt_d;
  logic [TMR_W-1:0] tmr, tmr_d;
  logic             wr1, wr2, capture, handshake;
  logic             row_ready_d, issue_d, valid_d, busy_d, clear_d;

  // Next-state and next-output decode; registered outputs follow the next state.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    tmr_d     = tmr;
    wr1       = 1'b0;
    wr2       = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    clear_d   = 1'b0;

    case (state)
      LOAD1: begin
        if (row_valid) begin
          wr1   = 1'b1;
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) state_d = LOAD2;
        end
      end
      LOAD2: begin
        if (row_valid) begin
          wr2   = 1'b1;
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_d = ISSUE;
            tmr_d   = '0;
          end
        end
      end
      ISSUE: begin
        if (tmr == HOLD_LAST) begin
          tmr_d = '0;
          if (SAMPLE_DELAY == 0) begin
            capture = 1'b1;
            state_d = REPORT;
          end else begin
            state_d = WAIT;
          end
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      WAIT: begin
        if (tmr == WAIT_LAST) begin
          tmr_d   = '0;
          capture = 1'b1;
          state_d = REPORT;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      REPORT: begin
        if (decision_ready) begin
          handshake = 1'b1;
          clear_d   = 1'b1;
          cnt_d     = 2'd0;
          state_d   = LOAD1;
        end
      end
      default: state_d = LOAD1;
    endcase

    row_ready_d = (state_d == LOAD1) || (state_d == LOAD2);
    issue_d     = (state_d == ISSUE);
    valid_d     = (state_d == REPORT);
    busy_d      = !row_ready_d;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state          <= LOAD1;
      cnt            <= '0;
      tmr            <= '0;
      row_ready      <= 1'b1;
      mean_enable    <= 1'b0;
      mean_compare   <= 1'b0;
      mean_clear     <= 1'b0;
      decision_valid <= 1'b0;
      decision_prune <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      tmr            <= tmr_d;
      row_ready      <= row_ready_d;
      mean_enable    <= issue_d;
      mean_compare   <= issue_d;
      mean_clear     <= clear_d;
      decision_valid <= valid_d;
      busy           <= busy_d;
      if (capture) decision_prune <= prune_head;
    end
  end

  // Matrix storage: rows land unmodified at row[cnt]; nothing else writes them.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      m1_flat <= '0;
      m2_flat <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (wr1 && (cnt == 2'(r))) m1_flat[r*ROW_W +: ROW_W] <= row_data;
        if (wr2 && (cnt == 2'(r))) m2_flat[r*ROW_W +: ROW_W] <= row_data;
      end
    end
  end

`ifdef PRUNE_STATS_EN
  // Saturating decision statistics, counted on the report handshake.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      head_cnt   <= '0;
      pruned_cnt <= '0;
    end else if (handshake) begin
      if (head_cnt != 8'hFF) head_cnt <= head_cnt + 8'd1;
      if (decision_prune && (pruned_cnt != 8'hFF)) pruned_cnt <= pruned_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_head_result_sequencer.sv
// Self-checking bench for head_result_sequencer: randomized rows/decisions against an
// abstract timing model (accept count, 8th-accept edge, capture edge).
module tb_head_result_sequencer;
  localparam int unsigned W  = 8;
  localparam int          H  = 2;
  localparam int          S  = 1;
  localparam int unsigned EW = 2 * W;
  localparam int unsigned RW = 8 * W;
  localparam int unsigned MW = 32 * W;
  localparam int          PERIOD = 8 + H + S + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          row_valid, row_ready;
  logic [RW-1:0] row_data;
  logic [MW-1:0] m1_flat, m2_flat;
  logic          mean_enable, mean_compare, prune_head, mean_clear;
  logic          decision_valid, decision_prune, decision_ready, busy;

  logic          b_row_valid, b_row_ready;
  logic [RW-1:0] b_row_data;
  logic [MW-1:0] b_m1_flat, b_m2_flat;
  logic          b_mean_enable, b_mean_compare, b_prune_head, b_mean_clear;
  logic          b_decision_valid, b_decision_prune, b_decision_ready, b_busy;
`ifdef PRUNE_STATS_EN
  logic [7:0]    head_cnt, pruned_cnt, b_head_cnt, b_pruned_cnt;
`endif

  head_result_sequencer #(.WIDTH(W), .HOLD_CYCLES(H), .SAMPLE_DELAY(S)) dut (
    .clk(clk), ._reset(rst_n), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .m1_flat(m1_flat), .m2_flat(m2_flat),
    .mean_enable(mean_enable), .mean_compare(mean_compare), .prune_head(prune_head),
    .mean_clear(mean_clear), .decision_valid(decision_valid),
    .decision_prune(decision_prune), .decision_ready(decision_ready),
`ifdef PRUNE_STATS_EN
    .head_cnt(head_cnt), .pruned_cnt(pruned_cnt),
`endif
    .busy(busy));

  head_result_sequencer #(.WIDTH(W), .HOLD_CYCLES(1), .SAMPLE_DELAY(0)) dut_fast (
    .clk(clk), ._reset(rst_n), .row_valid(b_row_valid), .row_ready(b_row_ready),
    .row_data(b_row_data), .m1_flat(b_m1_flat), .m2_flat(b_m2_flat),
    .mean_enable(b_mean_enable), .mean_compare(b_mean_compare), .prune_head(b_prune_head),
    .mean_clear(b_mean_clear), .decision_valid(b_decision_valid),
    .decision_prune(b_decision_prune), .decision_ready(b_decision_ready),
`ifdef PRUNE_STATS_EN
    .head_cnt(b_head_cnt), .pruned_cnt(b_pruned_cnt),
`endif
    .busy(b_busy));

  int total = 0;
  int bad   = 0;

  // Reference model: rows accepted this head, edge of the 8th accept, expected outputs.
  int            t = 0;
  int            acc, e0, heads, prunes;
  logic [EW-1:0] em [2][16];
  logic          m_ready, m_en, m_valid, m_clear, m_prune, m_busy;

  task automatic model_reset();
    acc = 0; e0 = 0; heads = 0; prunes = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) em[k][i] = '0;
    m_ready = 1'b1; m_en = 1'b0; m_valid = 1'b0; m_clear = 1'b0; m_prune = 1'b0; m_busy = 1'b0;
  endtask

  function automatic logic [MW-1:0] flat(input int k);
    logic [MW-1:0] f;
    for (int i = 0; i < 16; i++) f[i*EW +: EW] = em[k][i];
    return f;
  endfunction

  // Drive one cycle on the main DUT and advance the model across the edge.
  task automatic step(input logic rv, input logic [RW-1:0] rd, input logic dr, input logic ph);
    row_valid = rv; row_data = rd; decision_ready = dr; prune_head = ph;
    @(posedge clk);
    t++;
    m_clear = 1'b0;
    if (m_ready && rv) begin
      for (int c = 0; c < 4; c++) em[acc/4][(acc%4)*4 + c] = rd[c*EW +: EW];
      acc++;
      if (acc == 8) e0 = t;
    end else if (m_valid && dr) begin
      acc = 0;
      m_clear = 1'b1;
      if (heads < 255) heads++;
      if (m_prune && prunes < 255) prunes++;
    end
    if (acc == 8 && (t - e0) == H + S) m_prune = ph;
    m_ready = (acc < 8);
    m_busy  = (acc == 8);
    m_en    = (acc == 8) && ((t - e0) < H);
    m_valid = (acc == 8) && ((t - e0) >= H + S);
    #1;
  endtask

  task automatic drain();
    for (int g = 0; g < 4 * PERIOD && acc != 0; g++)
      step(1'b0, '0, 1'b1, 1'($urandom % 2));
  endtask

  task automatic test_reset();
    total++;
    if ({row_ready, busy, mean_enable, mean_compare, mean_clear, decision_valid, decision_prune} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b", {row_ready, busy, mean_enable, mean_compare, mean_clear, decision_valid, decision_prune}, 7'b1000000);
    end
    total++;
    if (m1_flat !== '0 || m2_flat !== '0) begin
      bad++; $display("FAIL reset_matrices got=%h/%h exp=0", m1_flat, m2_flat);
    end
    total++;
    if (b_row_ready !== 1'b1 || b_busy !== 1'b0) begin
      bad++; $display("FAIL reset_fast got=%b%b exp=10", b_row_ready, b_busy);
    end
  endtask

  task automatic test_directed_head();
    logic [RW-1:0] rd;
    int v, en_cnt, first_valid;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) begin
        v = 16 * (i % 4) + c;
        if (i >= 4) v = -v;
        rd[c*EW +: EW] = EW'(v);
      end
      step(1'b1, rd, 1'b0, 1'b0);
      total++;
      if (row_ready !== m_ready || busy !== m_busy) begin
        bad++; $display("FAIL dir_load_ready row=%0d got=%b%b exp=%b%b", i, row_ready, busy, m_ready, m_busy);
      end
    end
    total++;
    if (m1_flat[5*EW +: EW] !== 16'h0011) begin
      bad++; $display("FAIL dir_m1_elem5 got=%h exp=0011", m1_flat[5*EW +: EW]);
    end
    total++;
    if (m2_flat[5*EW +: EW] !== 16'hFFEF) begin
      bad++; $display("FAIL dir_m2_elem5 got=%h exp=ffef", m2_flat[5*EW +: EW]);
    end
    en_cnt = int'(mean_enable);
    first_valid = -1;
    for (int k = 1; k <= 8; k++) begin
      step((k < 8) ? 1'($urandom % 2) : 1'b0, {$urandom(), $urandom()}, 1'(k == 7),
           (k == 3) ? 1'b1 : 1'($urandom % 2));
      en_cnt += int'(mean_enable);
      if (decision_valid && first_valid < 0) first_valid = k;
      total++;
      if ({mean_enable, mean_compare, decision_valid, row_ready, busy} !== {m_en, m_en, m_valid, m_ready, m_busy}) begin
        bad++;
        $display("FAIL dir_ctrl k=%0d got=%b exp=%b", k, {mean_enable, mean_compare, decision_valid, row_ready, busy}, {m_en, m_en, m_valid, m_ready, m_busy});
      end
      total++;
      if (m1_flat !== flat(0) || m2_flat !== flat(1)) begin
        bad++; $display("FAIL dir_matrix_stable k=%0d got=%h exp=%h", k, m1_flat, flat(0));
      end
      if (k == 3) begin
        total++;
        if (decision_prune !== 1'b1) begin bad++; $display("FAIL dir_prune got=%b exp=1", decision_prune); end
      end
      if (k >= 7) begin
        total++;
        if (mean_clear !== 1'(k == 7)) begin
          bad++; $display("FAIL dir_clear k=%0d got=%b exp=%b", k, mean_clear, 1'(k == 7));
        end
      end
    end
    total++;
    if (en_cnt !== 2) begin bad++; $display("FAIL dir_enable_cycles got=%0d exp=2", en_cnt); end
    total++;
    if (first_valid !== 3) begin bad++; $display("FAIL dir_valid_latency got=%0d exp=3", first_valid); end
  endtask

  task automatic test_sparse_rows();
    int   acc_seen;
    logic rdy_before, rv;
    acc_seen = 0;
    for (int i = 0; i < 16; i++) begin
      rdy_before = row_ready;
      rv = 1'(i % 2 == 0);
      step(rv, {$urandom(), $urandom()}, 1'b0, 1'($urandom % 2));
      if (rv && rdy_before) acc_seen++;
      total++;
      if ({row_ready, mean_enable, busy} !== {m_ready, m_en, m_busy}) begin
        bad++; $display("FAIL sparse_ctrl i=%0d got=%b exp=%b", i, {row_ready, mean_enable, busy}, {m_ready, m_en, m_busy});
      end
      total++;
      if (m1_flat !== flat(0) || m2_flat !== flat(1)) begin
        bad++; $display("FAIL sparse_rows i=%0d got=%h/%h exp=%h/%h", i, m1_flat, m2_flat, flat(0), flat(1));
      end
    end
    total++;
    if (acc_seen !== 8) begin bad++; $display("FAIL sparse_accepts got=%0d exp=8", acc_seen); end
    drain();
    total++;
    if (decision_prune !== m_prune || row_ready !== 1'b1) begin
      bad++; $display("FAIL sparse_decision got=%b%b exp=%b1", decision_prune, row_ready, m_prune);
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 5; i++) step(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0);
    row_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({row_ready, busy, mean_enable, mean_compare, mean_clear, decision_valid, decision_prune} !== 7'b1000000) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b exp=%b", {row_ready, busy, mean_enable, mean_compare, mean_clear, decision_valid, decision_prune}, 7'b1000000);
    end
    total++;
    if (m1_flat !== '0 || m2_flat !== '0) begin
      bad++; $display("FAIL midrst_matrices got=%h/%h exp=0", m1_flat, m2_flat);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0);
      total++;
      if (m1_flat !== flat(0) || m2_flat !== flat(1)) begin
        bad++; $display("FAIL midrst_fresh i=%0d got=%h/%h exp=%h/%h", i, m1_flat, m2_flat, flat(0), flat(1));
      end
    end
    total++;
    if (mean_enable !== 1'b1 || mean_clear !== 1'b0) begin
      bad++; $display("FAIL midrst_issue got=%b%b exp=10", mean_enable, mean_clear);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int nheads, hs, last_hs, guard;
`ifdef PRUNE_STATS_EN
    nheads = 300;
`else
    nheads = 20;
`endif
    row_valid = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    hs = 0; last_hs = -1; guard = 0;
    while (hs < nheads && guard < nheads * 2 * PERIOD) begin
      step(1'b1, {$urandom(), $urandom()}, 1'b1, 1'(hs % 2 == 0));
      guard++;
      total++;
      if ({decision_valid, mean_clear, decision_prune, mean_enable, row_ready} !== {m_valid, m_clear, m_prune, m_en, m_ready}) begin
        bad++;
        $display("FAIL b2b_ctrl t=%0d got=%b exp=%b", t, {decision_valid, mean_clear, decision_prune, mean_enable, row_ready}, {m_valid, m_clear, m_prune, m_en, m_ready});
      end
      if (m_clear) begin
        if (last_hs >= 0) begin
          total++;
          if (t - last_hs !== PERIOD) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", t - last_hs, PERIOD); end
        end
        last_hs = t;
        hs++;
      end
`ifdef PRUNE_STATS_EN
      total++;
      if (head_cnt !== 8'(heads) || pruned_cnt !== 8'(prunes)) begin
        bad++; $display("FAIL b2b_stats got=%0d/%0d exp=%0d/%0d", head_cnt, pruned_cnt, heads, prunes);
      end
`endif
    end
    total++;
    if (hs !== nheads) begin bad++; $display("FAIL b2b_timeout got=%0d exp=%0d", hs, nheads); end
`ifdef PRUNE_STATS_EN
    total++;
    if (head_cnt !== 8'd255 || pruned_cnt !== 8'd150) begin
      bad++; $display("FAIL stats_final got=%0d/%0d exp=255/150", head_cnt, pruned_cnt);
    end
`endif
  endtask

  task automatic test_fast_path();
    logic [RW-1:0] rows [8];
    logic [MW-1:0] exp1, exp2;
    logic          v;
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 8; i++) begin
        b_row_valid = 1'b1;
        b_row_data  = {$urandom(), $urandom()};
        rows[i]     = b_row_data;
        b_prune_head = ~b_prune_head;
        @(posedge clk); #1;
      end
      b_row_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        exp1[i*RW +: RW] = rows[i];
        exp2[i*RW +: RW] = rows[i+4];
      end
      total++;
      if ({b_mean_enable, b_mean_compare, b_decision_valid, b_busy, b_row_ready} !== 5'b11010) begin
        bad++; $display("FAIL fast_issue h=%0d got=%b exp=11010", h, {b_mean_enable, b_mean_compare, b_decision_valid, b_busy, b_row_ready});
      end
      total++;
      if (b_m1_flat !== exp1 || b_m2_flat !== exp2) begin
        bad++; $display("FAIL fast_matrix h=%0d got=%h exp=%h", h, b_m1_flat, exp1);
      end
      b_prune_head = ~b_prune_head;
      v = b_prune_head;
      @(posedge clk); #1;
      total++;
      if ({b_mean_enable, b_decision_valid, b_decision_prune} !== {1'b0, 1'b1, v}) begin
        bad++; $display("FAIL fast_capture h=%0d got=%b exp=%b", h, {b_mean_enable, b_decision_valid, b_decision_prune}, {1'b0, 1'b1, v});
      end
      b_prune_head = ~b_prune_head;
      @(posedge clk); #1;
      total++;
      if (b_decision_prune !== v || b_decision_valid !== 1'b1) begin
        bad++; $display("FAIL fast_hold h=%0d got=%b%b exp=%b1", h, b_decision_prune, b_decision_valid, v);
      end
      b_decision_ready = 1'b1;
      @(posedge clk); #1;
      b_decision_ready = 1'b0;
      total++;
      if (b_mean_clear !== 1'b1 || b_decision_valid !== 1'b0 || b_decision_prune !== v) begin
        bad++; $display("FAIL fast_clear h=%0d got=%b%b%b exp=10%b", h, b_mean_clear, b_decision_valid, b_decision_prune, v);
      end
      if (h == 0) begin
        b_prune_head = ~b_prune_head;
        @(posedge clk); #1;
      end
    end
`ifdef PRUNE_STATS_EN
    total++;
    if (b_head_cnt !== 8'd2) begin bad++; $display("FAIL fast_stats got=%0d exp=2", b_head_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    row_valid = 1'b0; row_data = '0; decision_ready = 1'b0; prune_head = 1'b0;
    b_row_valid = 1'b0; b_row_data = '0; b_decision_ready = 1'b0; b_prune_head = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_directed_head();
    test_sparse_rows();
    test_reset_midload();
    test_back_to_back();
    test_fast_path();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/head_result_sequencer.md
# head_result_sequencer

Sequencing front end for the head-pruning mean/threshold unit. It accepts two 4x4 INT result matrices (Q·K-side and second product) row by row from the systolic array drain. It presents both matrices, stable, on flattened buses and drives the unit's enable/compare protocol. It then captures the returned prune decision and hands it downstream on a valid/ready handshake, clearing the mean unit between heads.

## Interface
- `WIDTH`, 8, operand width; result elements are 2*WIDTH signed bits.
- `HOLD_CYCLES`, 2, cycles `mean_enable`/`mean_compare` stay high per head (>=1).
- `SAMPLE_DELAY`, 1, cycles after ISSUE before `prune_head` is sampled (>=0).

- `clk`  in  1  rising-edge clock.
- `_reset`  in  1  asynchronous, active-low reset.
- `row_valid`  in  1  drain row available.
- `row_ready`  out  1  sequencer accepts a row this cycle.
- `row_data`  in  8*WIDTH  4 signed elements; column c at `[c*2*WIDTH +: 2*WIDTH]`.
- `m1_flat`, `m2_flat`  out  32*WIDTH each  matrix 1/2; element [r][c] at `[(r*4+c)*2*WIDTH +: 2*WIDTH]`.
- `mean_enable`  out  1  accumulate strobe to mean unit.
- `mean_compare`  out  1  compare-with-threshold strobe to mean unit.
- `prune_head`  in  1  decision from mean unit.
- `mean_clear`  out  1  one-cycle clear pulse to mean unit.
- `decision_valid`  out  1  decision available.
- `decision_prune`  out  1  captured decision (1 = prune head).
- `decision_ready`  in  1  downstream accepts decision.
- `busy`  out  1  high in ISSUE, WAIT, REPORT.

## Operation
- States: LOAD1, LOAD2, ISSUE, WAIT, REPORT. Reset state is LOAD1.
- Row counter is 2 bits, 0..3.
- LOAD1/LOAD2: `row_ready`=1. On `row_valid&row_ready`, `row_data` is written to row[cnt] of matrix 1 (LOAD1) or matrix 2 (LOAD2), and cnt increments.
  - cnt wrap 3->0 moves LOAD1->LOAD2 and LOAD2->ISSUE.
- ISSUE: `mean_enable`=`mean_compare`=1 for exactly HOLD_CYCLES cycles, then WAIT. If SAMPLE_DELAY=0, ISSUE goes straight to REPORT.
- WAIT: SAMPLE_DELAY cycles. The final edge captures `prune_head` into `decision_prune` and moves to REPORT.
- REPORT: `decision_valid`=1 until `decision_ready`.
  - The handshake edge moves to LOAD1, zeroes cnt, and registers `mean_clear`=1 for the next single cycle.
- Row acceptance is permitted during the `mean_clear` cycle.
- Elements are passed unmodified: no sign extension, truncation or reorder.
- `m1_flat`/`m2_flat` change only on row writes, so they are stable throughout ISSUE/WAIT/REPORT.
- `row_ready`=0 outside LOAD states. `row_valid` is ignored there and no storage changes.

## Timing
- Reset values:
  - `row_ready`=1 (state LOAD1).
  - `m1_flat`, `m2_flat`, `mean_enable`, `mean_compare`, `mean_clear`, `decision_valid`, `decision_prune` and `busy` are all 0.
  - Counters are 0.
- 8th row accepted at edge E0:
  - ISSUE occupies the cycles after E0+1 .. E0+HOLD_CYCLES.
  - Capture happens at edge E0+HOLD_CYCLES+SAMPLE_DELAY.
  - `decision_valid` is high from that edge; defaults give 3 cycles.
- Minimum throughput is 8 + HOLD_CYCLES + SAMPLE_DELAY + 1 cycles per head with `row_valid` and `decision_ready` held high.
- If `decision_ready` is already high on REPORT entry, the handshake completes in REPORT's first cycle.
- `decision_prune` holds its value after the handshake until the next capture.
- `_reset` low at any time, including mid-load or mid-REPORT:
  - All state, matrices and counters clear immediately.
  - Partial matrices and any pending decision are discarded.
  - No `mean_clear` pulse is produced.

## Configuration
- `PRUNE_STATS_EN` defined adds two outputs:
  - `head_cnt` [7:0]: decisions handshaken.
  - `pruned_cnt` [7:0]: decisions handshaken with `decision_prune`=1.
  - Both count at the REPORT handshake edge, saturate at 255, and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then 8 back-to-back rows with element value = 16*r + c (matrix 2: negated) -> `m1_flat`[5] = 0x0011 and `m2_flat`[5] = 0xFFEF. Enable/compare are high exactly 2 cycles starting the cycle after the 8th accept, then `decision_valid` rises 3 cycles after that accept.
- `prune_head`=1 at the capture edge with `decision_ready` low for 4 cycles -> `decision_valid` held 4 cycles, `decision_prune`=1, `row_ready`=0 throughout, `row_valid` pulses ignored. After ready, `mean_clear` is high for exactly 1 cycle.
- `row_valid` toggling every other cycle -> exactly 8 accepts, row order preserved, ISSUE entered only after the 8th.
- `_reset` asserted after 5 rows -> all outputs return to reset values at once. The following 8 rows form a fresh head with no residue from the aborted one.
- SAMPLE_DELAY=0, HOLD_CYCLES=1 -> one enable cycle, capture at E0+1, with the mean unit's `prune_head` toggled between capture cycles to confirm the sampling edge.
- `PRUNE_STATS_EN`: 300 heads alternating prune 1/0 -> `head_cnt`=255 and `pruned_cnt`=150.
